// File: rtl/debug_unit_pkg.sv
// Shared encodings for the host-side pipeline debug controller.
// States, host command bytes and dump layout constants.
package debug_unit_pkg;

    typedef enum logic [3:0] {
        S_IDLE,
        S_LOAD_CNT,
        S_LOAD_BYTE,
        S_LOAD_WRITE,
        S_ACK,
        S_ACK_WAIT,
        S_RUN,
        S_STEP,
        S_DUMP_ADDR,
        S_DUMP_WAIT,
        S_DUMP_SEND
    } state_t;

    localparam logic [7:0] CMD_LOAD = 8'h4C;
    localparam logic [7:0] CMD_RUN  = 8'h43;
    localparam logic [7:0] CMD_STEP = 8'h53;
    localparam logic [7:0] CMD_DUMP = 8'h44;
    localparam logic [7:0] ACK_BYTE = 8'h4B;

    localparam logic [31:0] MEM_BASE = 32'h0;

    localparam int DEF_N_REGS      = 32;
    localparam int DEF_N_MEM_WORDS = 16;

    function automatic int dump_bytes(input int n_regs, input int n_mem,
                                      input int bytes_per_word);
        return bytes_per_word * (n_regs + n_mem);
    endfunction

    localparam int DUMP_BYTES = dump_bytes(DEF_N_REGS, DEF_N_MEM_WORDS, 4);

endpackage

// File: rtl/du_word_serializer.sv
// Sends one word to the UART transmitter, MSB byte first,
// waiting for tx_done after every byte before launching the next.
module du_word_serializer #(
    parameter int NB_REG  = 32,
    parameter int NB_BYTE = 8
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               load,
    input  logic [NB_REG-1:0]  word,
    input  logic               tx_done,
    output logic [NB_BYTE-1:0] tx_data,
    output logic               tx_start,
    output logic               busy,
    output logic               last
);
    localparam int BPW = NB_REG / NB_BYTE;
    localparam int BW  = $clog2(BPW);

    logic [NB_REG-1:0] sreg;
    logic [BW-1:0]     idx;
    logic              pend;

    assign tx_start = busy && !pend;
    assign tx_data  = sreg[NB_REG-1 -: NB_BYTE];
    assign last     = pend && tx_done && (idx == BW'(BPW - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            sreg <= '0;
            idx  <= '0;
            pend <= 1'b0;
            busy <= 1'b0;
        end else if (load && !busy) begin
            sreg <= word;
            idx  <= '0;
            busy <= 1'b1;
        end else if (tx_start) begin
            pend <= 1'b1;
        end else if (pend && tx_done) begin
            pend <= 1'b0;
            if (idx == BW'(BPW - 1)) begin
                busy <= 1'b0;
            end else begin
                idx  <= idx + 1'b1;
                sreg <= sreg << NB_BYTE;
            end
        end
    end

endmodule

// File: rtl/debug_unit.sv
// Host command decoder driving the pipeline debug port:
// program load, run, single step and register/memory dump over UART.
module debug_unit
    import debug_unit_pkg::*;
#(
    parameter int NB_REG      = 32,
    parameter int NB_BYTE     = 8,
    parameter int N_REGS      = 32,
    parameter int N_MEM_WORDS = 16
) (
    input  logic               i_clk,
    input  logic               i_reset,
    input  logic [NB_BYTE-1:0] i_rx_data,
    input  logic               i_rx_done,
    output logic [NB_BYTE-1:0] o_tx_data,
    output logic               o_tx_start,
    input  logic               i_tx_done,
    input  logic               i_halt,
    output logic               o_dunit_clk_en,
    output logic               o_dunit_reset_pc,
    output logic               o_dunit_w_mem,
    output logic [NB_REG-1:0]  o_dunit_addr,
    output logic [NB_REG-1:0]  o_dunit_data_if,
    input  logic [NB_REG-1:0]  i_dunit_reg,
    input  logic [NB_REG-1:0]  i_dunit_mem_data
);
    localparam int N_ITEMS = N_REGS + N_MEM_WORDS;
    localparam int IW      = $clog2(N_ITEMS);
    localparam int BPW     = NB_REG / NB_BYTE;
    localparam int BW      = $clog2(BPW);
    localparam logic [IW-1:0] LAST_ITEM = IW'(N_ITEMS - 1);

    state_t state, next_state;

    logic               reset_pc;
    logic [NB_REG-1:0]  word;
    logic [BW-1:0]      byte_cnt;
    logic [NB_BYTE-1:0] left;
    logic [NB_REG-1:0]  k;
    logic [IW-1:0]      item;

    logic               clk_en, w_mem, ser_load, ack_start;
    logic               ser_start, ser_busy, ser_last;
    logic [NB_BYTE-1:0] ser_data;
    logic               is_reg;
    logic               in_dump;

    assign is_reg  = item < IW'(N_REGS);
    assign in_dump = (state == S_DUMP_ADDR) || (state == S_DUMP_WAIT) ||
                     (state == S_DUMP_SEND);

    always_ff @(posedge i_clk) begin
        if (i_reset) state <= S_IDLE;
        else         state <= next_state;
    end

    always_comb begin
        next_state = state;
        clk_en     = 1'b0;
        w_mem      = 1'b0;
        ser_load   = 1'b0;
        ack_start  = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (i_rx_done) begin
                    unique case (1'b1)
                        i_rx_data == NB_BYTE'(CMD_LOAD): next_state = S_LOAD_CNT;
                        i_rx_data == NB_BYTE'(CMD_RUN):
                            next_state = i_halt ? S_DUMP_ADDR : S_RUN;
                        i_rx_data == NB_BYTE'(CMD_STEP): next_state = S_STEP;
                        i_rx_data == NB_BYTE'(CMD_DUMP): next_state = S_DUMP_ADDR;
                        default: next_state = S_IDLE;
                    endcase
                end
            end
            S_LOAD_CNT: begin
                if (i_rx_done)
                    next_state = (i_rx_data == '0) ? S_IDLE : S_LOAD_BYTE;
            end
            S_LOAD_BYTE: begin
                if (i_rx_done && byte_cnt == BW'(BPW - 1))
                    next_state = S_LOAD_WRITE;
            end
            S_LOAD_WRITE: begin
                w_mem      = 1'b1;
                next_state = (left == NB_BYTE'(1)) ? S_ACK : S_LOAD_BYTE;
            end
            S_ACK: begin
                ack_start  = 1'b1;
                next_state = S_ACK_WAIT;
            end
            S_ACK_WAIT: begin
                if (i_tx_done) next_state = S_IDLE;
            end
            S_RUN: begin
                // halt gates the enable combinationally so no extra cycle slips through
                if (i_halt) next_state = S_DUMP_ADDR;
                else        clk_en     = 1'b1;
            end
            S_STEP: begin
                clk_en     = 1'b1;
                next_state = S_DUMP_ADDR;
            end
            S_DUMP_ADDR: next_state = S_DUMP_WAIT;
            S_DUMP_WAIT: begin
                ser_load   = !ser_busy;
                next_state = S_DUMP_SEND;
            end
            S_DUMP_SEND: begin
                if (ser_last)
                    next_state = (item == LAST_ITEM) ? S_IDLE : S_DUMP_ADDR;
            end
            default: next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            reset_pc <= 1'b1;
            word     <= '0;
            byte_cnt <= '0;
            left     <= '0;
            k        <= '0;
            item     <= '0;
        end else begin
            if (state == S_IDLE && i_rx_done) begin
                if (i_rx_data == NB_BYTE'(CMD_LOAD))
                    reset_pc <= 1'b1;
                if (i_rx_data == NB_BYTE'(CMD_RUN) || i_rx_data == NB_BYTE'(CMD_STEP))
                    reset_pc <= 1'b0;
            end
            if (state == S_LOAD_CNT && i_rx_done) begin
                left     <= i_rx_data;
                k        <= '0;
                byte_cnt <= '0;
            end
            if (state == S_LOAD_BYTE && i_rx_done) begin
                word     <= {word[NB_REG-NB_BYTE-1:0], i_rx_data};
                byte_cnt <= byte_cnt + 1'b1;
            end
            if (state == S_LOAD_WRITE) begin
                k    <= k + 1'b1;
                left <= left - 1'b1;
            end
            if (state == S_DUMP_SEND && ser_last)
                item <= (item == LAST_ITEM) ? '0 : item + 1'b1;
        end
    end

    always_comb begin
        o_dunit_addr = '0;
        if (state == S_LOAD_WRITE)
            o_dunit_addr = k << 2;
        else if (in_dump && is_reg)
            o_dunit_addr = NB_REG'(item);
        else if (in_dump)
            o_dunit_addr = NB_REG'(MEM_BASE) + (NB_REG'(item - IW'(N_REGS)) << 2);
    end

    du_word_serializer #(
        .NB_REG (NB_REG),
        .NB_BYTE(NB_BYTE)
    ) u_ser (
        .clk     (i_clk),
        .reset   (i_reset),
        .load    (ser_load),
        .word    (is_reg ? i_dunit_reg : i_dunit_mem_data),
        .tx_done (i_tx_done),
        .tx_data (ser_data),
        .tx_start(ser_start),
        .busy    (ser_busy),
        .last    (ser_last)
    );

    assign o_tx_start       = ser_start | ack_start;
    assign o_tx_data        = (state == S_ACK) ? NB_BYTE'(ACK_BYTE) : ser_data;
    assign o_dunit_clk_en   = clk_en;
    assign o_dunit_reset_pc = reset_pc;
    assign o_dunit_w_mem    = w_mem;
    assign o_dunit_data_if  = (state == S_LOAD_WRITE) ? word : '0;

endmodule

// File: tb/tb_debug_unit.sv
// Randomized bench for debug_unit with a UART/pipeline model
// and a per-cycle monitor checking against queued expectations.
module tb_debug_unit;
    import debug_unit_pkg::*;

    localparam int N_REGS = 32;
    localparam int N_MEM  = 16;

    typedef struct {
        logic [31:0] addr;
        logic [31:0] data;
    } wexp_t;

    logic        i_clk = 1'b0;
    logic        i_reset = 1'b1;
    logic [7:0]  i_rx_data = 8'h0;
    logic        i_rx_done = 1'b0;
    logic [7:0]  o_tx_data;
    logic        o_tx_start;
    logic        i_tx_done;
    logic        i_halt;
    logic        o_dunit_clk_en;
    logic        o_dunit_reset_pc;
    logic        o_dunit_w_mem;
    logic [31:0] o_dunit_addr;
    logic [31:0] o_dunit_data_if;
    logic [31:0] i_dunit_reg;
    logic [31:0] i_dunit_mem_data;

    logic [31:0] regs [N_REGS];
    logic [31:0] mem  [N_MEM];

    logic [7:0] exp_tx [$];
    wexp_t      exp_w  [$];

    int n_checks = 0;
    int n_errors = 0;
    int en_total = 0;
    int w_total  = 0;
    int tx_total = 0;
    bit outstanding = 0;
    bit slow = 0;
    bit halt_force = 0;
    bit halt_armed = 0;
    int halt_after = 0;
    int en_start = 0;

    debug_unit dut (
        .i_clk           (i_clk),
        .i_reset         (i_reset),
        .i_rx_data       (i_rx_data),
        .i_rx_done       (i_rx_done),
        .o_tx_data       (o_tx_data),
        .o_tx_start      (o_tx_start),
        .i_tx_done       (i_tx_done),
        .i_halt          (i_halt),
        .o_dunit_clk_en  (o_dunit_clk_en),
        .o_dunit_reset_pc(o_dunit_reset_pc),
        .o_dunit_w_mem   (o_dunit_w_mem),
        .o_dunit_addr    (o_dunit_addr),
        .o_dunit_data_if (o_dunit_data_if),
        .i_dunit_reg     (i_dunit_reg),
        .i_dunit_mem_data(i_dunit_mem_data)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Pipeline read port: one cycle of latency on the debug address.
    initial begin
        logic [31:0] a;
        i_dunit_reg = '0;
        i_dunit_mem_data = '0;
        forever begin
            @(negedge i_clk);
            a = o_dunit_addr;
            @(posedge i_clk);
            #1;
            i_dunit_reg = (a < 32) ? regs[a[4:0]] : 32'hDEAD_BEEF;
            i_dunit_mem_data = (a < 64 && a[1:0] == 2'b00) ? mem[a[5:2]] : 32'hBAD0_BAD0;
        end
    end

    // Pipeline halt: raised after a chosen number of enabled cycles.
    initial begin
        i_halt = 1'b0;
        forever begin
            @(posedge i_clk);
            #1;
            i_halt = halt_force || (halt_armed && (en_total - en_start) >= halt_after);
        end
    end

    // UART transmitter: done strobe a few cycles after each start.
    initial begin
        int d;
        i_tx_done = 1'b0;
        forever begin
            @(negedge i_clk);
            if (o_tx_start && !i_reset) begin
                d = slow ? 50 : int'($urandom_range(1, 4));
                repeat (d) @(posedge i_clk);
                #1 i_tx_done = 1'b1;
                @(posedge i_clk);
                #1 i_tx_done = 1'b0;
            end
        end
    end

    always @(negedge i_clk) begin
        if (i_reset) begin
            outstanding = 0;
        end else begin
            if (o_dunit_clk_en) begin
                en_total++;
                chk("reset_pc_while_enabled", 32'(o_dunit_reset_pc), 0);
            end
            if (o_dunit_w_mem) begin
                w_total++;
                chk("clk_en_during_load", 32'(o_dunit_clk_en), 0);
                chk("reset_pc_during_load", 32'(o_dunit_reset_pc), 1);
                chk("w_mem_expected", 32'(exp_w.size() > 0), 1);
                if (exp_w.size() > 0) begin
                    wexp_t e;
                    e = exp_w.pop_front();
                    chk("w_addr", o_dunit_addr, e.addr);
                    chk("w_data", o_dunit_data_if, e.data);
                end
            end
            if (i_tx_done) outstanding = 0;
            if (o_tx_start) begin
                tx_total++;
                chk("tx_start_while_outstanding", 32'(outstanding), 0);
                chk("tx_expected", 32'(exp_tx.size() > 0), 1);
                if (exp_tx.size() > 0)
                    chk("tx_byte", 32'(o_tx_data), 32'(exp_tx.pop_front()));
                outstanding = 1;
            end
        end
    end

    task automatic randomize_state();
        for (int i = 0; i < N_REGS; i++) regs[i] = $urandom;
        for (int i = 0; i < N_MEM; i++) mem[i] = $urandom;
    endtask

    task automatic push_dump();
        for (int i = 0; i < N_REGS; i++)
            for (int b = 3; b >= 0; b--) exp_tx.push_back(regs[i][8*b +: 8]);
        for (int i = 0; i < N_MEM; i++)
            for (int b = 3; b >= 0; b--) exp_tx.push_back(mem[i][8*b +: 8]);
    endtask

    task automatic send(input logic [7:0] b);
        @(posedge i_clk);
        #1;
        i_rx_data = b;
        i_rx_done = 1'b1;
        @(posedge i_clk);
        #1;
        i_rx_done = 1'b0;
        repeat ($urandom_range(0, 2)) @(posedge i_clk);
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int b = 3; b >= 0; b--) send(w[8*b +: 8]);
    endtask

    task automatic drain(input string name, input int budget);
        int c = 0;
        while ((exp_tx.size() != 0 || exp_w.size() != 0 || outstanding) && c < budget) begin
            @(posedge i_clk);
            c++;
        end
        chk(name, 32'(c < budget), 1);
        repeat (3) @(posedge i_clk);
    endtask

    task automatic do_reset();
        @(posedge i_clk);
        #1 i_reset = 1'b1;
        exp_tx.delete();
        exp_w.delete();
        @(posedge i_clk);
        @(negedge i_clk);
        chk("rst_clk_en", 32'(o_dunit_clk_en), 0);
        chk("rst_reset_pc", 32'(o_dunit_reset_pc), 1);
        chk("rst_tx_start", 32'(o_tx_start), 0);
        chk("rst_w_mem", 32'(o_dunit_w_mem), 0);
        chk("rst_tx_data", 32'(o_tx_data), 0);
        chk("rst_addr", o_dunit_addr, 0);
        chk("rst_data_if", o_dunit_data_if, 0);
        @(posedge i_clk);
        #1 i_reset = 1'b0;
    endtask

    task automatic random_load(input int n);
        logic [31:0] w;
        int w0;
        w0 = w_total;
        send(CMD_LOAD);
        send(8'(n));
        for (int k = 0; k < n; k++) begin
            w = $urandom;
            exp_w.push_back('{addr: 32'(4 * k), data: w});
            if (k == n - 1) exp_tx.push_back(ACK_BYTE);
            send_word(w);
        end
        drain("load_drain", 2000);
        chk("load_count", w_total - w0, n);
    endtask

    task automatic dump_cmd(input logic [7:0] cmd, input int exp_en, input string name);
        int e0, t0;
        e0 = en_total;
        t0 = tx_total;
        push_dump();
        send(cmd);
        drain(name, 8000);
        chk({name, "_enabled"}, en_total - e0, exp_en);
        chk({name, "_bytes"}, tx_total - t0, 192);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        int w0, t0, e0, h;
        randomize_state();
        do_reset();

        e0 = en_total;
        exp_w.push_back('{addr: 32'h0, data: 32'h0800_0010});
        exp_w.push_back('{addr: 32'h4, data: 32'h0C00_0014});
        exp_tx.push_back(8'h4B);
        w0 = w_total;
        send(8'h4C); send(8'h02);
        send(8'h08); send(8'h00); send(8'h00); send(8'h10);
        send(8'h0C); send(8'h00); send(8'h00); send(8'h14);
        drain("load2_drain", 2000);
        chk("load2_writes", w_total - w0, 2);
        chk("load2_enabled", en_total - e0, 0);

        w0 = w_total;
        t0 = tx_total;
        send(8'h4C); send(8'h00);
        repeat (6) @(posedge i_clk);
        chk("load0_writes", w_total - w0, 0);
        chk("load0_tx", tx_total - t0, 0);
        dump_cmd(CMD_DUMP, 0, "dump_after_load0");

        send(8'h5A);
        repeat (4) @(posedge i_clk);
        chk("junk_ignored_tx", tx_total - t0, 192);

        for (int i = 0; i < 3; i++) random_load(int'($urandom_range(1, 6)));

        randomize_state();
        regs[0] = 32'hA1B2_C3D4;
        exp_tx.push_back(8'hA1); exp_tx.push_back(8'hB2);
        exp_tx.push_back(8'hC3); exp_tx.push_back(8'hD4);
        for (int b = 3; b >= 0; b--) void'(exp_tx.pop_back());
        dump_cmd(CMD_STEP, 1, "step1");
        @(negedge i_clk);
        chk("reset_pc_after_step", 32'(o_dunit_reset_pc), 0);
        randomize_state();
        dump_cmd(CMD_STEP, 1, "step2");
        random_load(1);

        randomize_state();
        halt_after = 7;
        en_start = en_total;
        halt_armed = 1;
        dump_cmd(CMD_RUN, 7, "run7");
        halt_armed = 0;
        repeat (2) @(posedge i_clk);

        for (int i = 0; i < 2; i++) begin
            h = int'($urandom_range(1, 20));
            randomize_state();
            halt_after = h;
            en_start = en_total;
            halt_armed = 1;
            dump_cmd(CMD_RUN, h, "run_rand");
            halt_armed = 0;
            repeat (2) @(posedge i_clk);
        end

        halt_force = 1;
        repeat (2) @(posedge i_clk);
        randomize_state();
        dump_cmd(CMD_RUN, 0, "run_halted");
        halt_force = 0;
        repeat (2) @(posedge i_clk);

        slow = 1;
        randomize_state();
        e0 = en_total;
        w0 = w_total;
        t0 = tx_total;
        push_dump();
        send(CMD_DUMP);
        for (int i = 0; i < 10; i++) begin
            repeat ($urandom_range(20, 60)) @(posedge i_clk);
            case (i % 5)
                0: send(CMD_LOAD);
                1: send(CMD_RUN);
                2: send(CMD_STEP);
                3: send(CMD_DUMP);
                default: send(8'($urandom));
            endcase
        end
        drain("slow_drain", 20000);
        chk("slow_bytes", tx_total - t0, 192);
        chk("slow_enabled", en_total - e0, 0);
        chk("slow_writes", w_total - w0, 0);
        slow = 0;

        e0 = en_total;
        send(CMD_RUN);
        repeat (10) @(posedge i_clk);
        chk("run_before_reset", 32'(en_total - e0 > 5), 1);
        do_reset();
        randomize_state();
        dump_cmd(CMD_DUMP, 0, "dump_after_reset");

        send(CMD_LOAD); send(8'h02); send(8'hAA); send(8'hBB);
        do_reset();
        w0 = w_total;
        exp_w.push_back('{addr: 32'h0, data: 32'h1357_9BDF});
        exp_tx.push_back(ACK_BYTE);
        send(CMD_LOAD); send(8'h01);
        send_word(32'h1357_9BDF);
        drain("reload_drain", 2000);
        chk("reload_writes", w_total - w0, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
